button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Front-end conditioning stage between the five raw board push-buttons and direction_logic; it feeds direction_logic's in_button_* inputs.
- Synchronises each asynchronous button into the clock domain and filters contact bounce with a per-button stability counter.
- Drives clean level outputs plus single-cycle press pulses, so downstream logic sees exactly one event per physical press.

Parameters:
- NUM_BUTTONS, 5, number of button channels; bit map 0=up, 1=down, 2=left, 3=right, 4=reset.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a new level (5 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), stability counter width (derived; not overridden).
- REPEAT_CYCLES, 25000000, auto-repeat period; used only with the optional feature.

Ports:
- in_clk  input  1  system clock; all state updates on its rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_buttons_raw  input  NUM_BUTTONS  raw asynchronous button levels, active-high.
- out_button_up  output  1  debounced level, bit 0.
- out_button_down  output  1  debounced level, bit 1.
- out_button_left  output  1  debounced level, bit 2.
- out_button_right  output  1  debounced level, bit 3.
- out_button_reset  output  1  debounced level, bit 4.
- out_pressed  output  NUM_BUTTONS  one-cycle pulse per accepted 0->1 transition, same bit map.

Behaviour:
- Reset (in_rst=1 at a clock edge): both synchroniser flops, all counters, all levels and out_pressed go to 0; every channel enters S_LOW. Reset dominates every other event.
- Synchroniser: two flops per bit (sync1, sync2). Only sync2 is used downstream.
- Per-channel FSM with four states:
  - S_LOW: level=0. If sync2=1, go to S_CHK_HI and set count=1.
  - S_CHK_HI: if sync2=0, return to S_LOW and clear count. Otherwise, when count==DEBOUNCE_CYCLES-1, go to S_HIGH, set level=1, pulse=1 for that one cycle. Otherwise count+1.
  - S_HIGH: level=1. If sync2=0, go to S_CHK_LO and set count=1.
  - S_CHK_LO: mirror of S_CHK_HI. On completion go to S_LOW and set level=0. No pulse on release.
- Latency: raw held stable from edge k gives a level change visible after edge k+1+DEBOUNCE_CYCLES; out_pressed is high for exactly that one cycle.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES returns the channel to its stable state with no output change and no pulse.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Channel independence: channels are fully independent. Simultaneous presses produce simultaneous pulses; no priority is applied here (direction_logic resolves conflicts).
- Reset button: out_button_reset is an ordinary debounced channel. It does not reset this block; in_rst does.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
- When defined: channels 0-3 (directions) in S_HIGH run a repeat counter. out_pressed re-pulses for one cycle every REPEAT_CYCLES cycles while held. The counter clears on leaving S_HIGH and on reset. Channel 4 never repeats.
- When undefined: no repeat counter is synthesised; exactly one pulse per press.

Decomposition:
- Shared package button_pkg:
  - button index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_RESET=4;
  - NUM_BUTTONS;
  - FSM state encodings S_LOW, S_CHK_HI, S_HIGH, S_CHK_LO (2 bits).
- One natural sub-module: debounce_channel (synchroniser + FSM + counter + pulse for one bit).
- button_debouncer instantiates NUM_BUTTONS copies via generate and maps bits to the named level ports.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8 in simulation):
- Reset: hold in_rst=1 with in_buttons_raw=5'b11111 for 3 cycles -> all levels 0, out_pressed=0. Release -> up/down/left/right/reset levels rise after edge 1+4 and out_pressed=5'b11111 for exactly one cycle.
- Clean press: raw bit 0 rises before edge 10 and is held -> out_button_up=1 after edge 15; out_pressed[0]=1 only in that cycle. Release -> level falls 5 edges later; no pulse.
- Bounce: raw bit 2 toggles 1,0,1,0 every 2 cycles, then stays 0 -> out_button_left stays 0 and out_pressed[2] never asserts.
- Reset mid-count: raw bit 3 high for 3 cycles, assert in_rst for 1 cycle, keep raw high -> counter restarts; level rises 1+4 edges after reset release, not earlier.
- Simultaneous: raw bits 0 and 3 rise on the same edge -> out_pressed=5'b01001 in a single cycle.
- Auto-repeat (macro defined): hold bit 1 for 30 cycles after acceptance -> out_pressed[1] pulses at acceptance and every 8 cycles thereafter (4 pulses in total). Macro undefined -> 1 pulse.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: channel bit map,
// default channel count and the per-channel debounce FSM encoding.
package button_pkg;

   // Bit positions of the board buttons inside in_buttons_raw / out_pressed
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_RESET = 4;

   localparam int NUM_BUTTONS = 5;

   // Debounce FSM: two stable states, each with a "checking" state on the way out
   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_CHK_HI = 2'd1,
      S_HIGH   = 2'd2,
      S_CHK_LO = 2'd3
   } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter FSM and a
// registered single-cycle press pulse. With BUTTON_DEBOUNCER_AUTOREPEAT_EN
// defined, a held channel (REPEAT_EN=1) re-pulses every REPEAT_CYCLES cycles.
module debounce_channel
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   ,
   parameter int REPEAT_CYCLES   = 25000000,
   parameter bit REPEAT_EN       = 1'b1
`endif
)(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic pulse
);
   import button_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   localparam logic [RPT_W-1:0] RPT_ZERO = RPT_W'(0);
   logic [RPT_W-1:0] rpt;
`endif

   logic             sync1;
   logic             sync2;
   db_state_t        state;
   logic [CNT_W-1:0] count;

   // Synchroniser, debounce FSM, stability counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= S_LOW;
         count <= CNT_ZERO;
         level <= 1'b0;
         pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
         rpt   <= RPT_ZERO;
`endif
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
         // Repeat timing only advances in S_HIGH; everywhere else it is held clear
         rpt   <= RPT_ZERO;
`endif
         case (state)
            S_LOW: begin
               level <= 1'b0;
               if (sync2) begin
                  state <= S_CHK_HI;
                  count <= CNT_ONE;
               end else begin
                  count <= CNT_ZERO;
               end
            end
            S_CHK_HI: begin
               level <= 1'b0;
               if (!sync2) begin
                  state <= S_LOW;
                  count <= CNT_ZERO;
               end else if (count == CNT_LAST) begin
                  // Accepted press: level and pulse change on the same edge
                  state <= S_HIGH;
                  count <= CNT_ZERO;
                  level <= 1'b1;
                  pulse <= 1'b1;
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            S_HIGH: begin
               level <= 1'b1;
               if (!sync2) begin
                  state <= S_CHK_LO;
                  count <= CNT_ONE;
               end else begin
                  count <= CNT_ZERO;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                  if (REPEAT_EN) begin
                     if (rpt == RPT_LAST) begin
                        rpt   <= RPT_ZERO;
                        pulse <= 1'b1;
                     end else begin
                        rpt <= rpt + RPT_W'(1);
                     end
                  end else begin
                     rpt <= RPT_ZERO;
                  end
`endif
               end
            end
            S_CHK_LO: begin
               level <= 1'b1;
               if (sync2) begin
                  state <= S_HIGH;
                  count <= CNT_ZERO;
               end else if (count == CNT_LAST) begin
                  // Accepted release: no pulse
                  state <= S_LOW;
                  count <= CNT_ZERO;
                  level <= 1'b0;
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            default: begin
               state <= S_LOW;
               count <= CNT_ZERO;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioning front end: NUM_BUTTONS independent debounce
// channels feeding direction_logic. Optional auto-repeat on the four
// direction channels is enabled by defining BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
#(
   parameter int NUM_BUTTONS     = button_pkg::NUM_BUTTONS,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
)(
   input  logic                   in_clk,
   input  logic                   in_rst,
   input  logic [NUM_BUTTONS-1:0] in_buttons_raw,
   output logic                   out_button_up,
   output logic                   out_button_down,
   output logic                   out_button_left,
   output logic                   out_button_right,
   output logic                   out_button_reset,
   output logic [NUM_BUTTONS-1:0] out_pressed
);
   import button_pkg::*;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   // Reject configurations the channel FSM cannot honour
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("button_debouncer: REPEAT_CYCLES must be >= 2");
   end
   if (NUM_BUTTONS != 5) begin : g_bad_width
      $error("button_debouncer: named level ports assume exactly 5 buttons");
   end

   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] pulse;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
         ,
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .REPEAT_EN       (1'(i < BTN_RESET))
`endif
      ) u_chan (
         .clk   (in_clk),
         .rst   (in_rst),
         .raw   (in_buttons_raw[i]),
         .level (level[i]),
         .pulse (pulse[i])
      );
   end

   // Channel outputs are already registered; these are pure renames
   assign out_button_up    = level[BTN_UP];
   assign out_button_down  = level[BTN_DOWN];
   assign out_button_left  = level[BTN_LEFT];
   assign out_button_right = level[BTN_RIGHT];
   assign out_button_reset = level[BTN_RESET];
   assign out_pressed      = pulse;

endmodule
